// File: rtl/opb_simulink_master.sv
// Single-outstanding OPB master: turns a user command/response handshake into
// OPB request/select transfers with retry back-off and acknowledge timeout.
module opb_simulink_master #(
  parameter int unsigned C_OPB_AWIDTH     = 32,
  parameter int unsigned C_OPB_DWIDTH     = 32,
  parameter int unsigned C_TIMEOUT_CYCLES = 16,
  parameter int unsigned C_MAX_RETRY      = 3
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  // user command side
  input  logic                        cmd_valid,
  input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
  input  logic                        cmd_rnw,
  output logic                        cmd_ready,
  output logic                        rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  // OPB master side
  output logic                        M_request,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic                        M_seqAddr,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  input  logic                        OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        Sl_xferAck,
  input  logic                        Sl_errAck,
  input  logic                        Sl_retry,
  input  logic                        Sl_toutSup
);

  localparam int unsigned AW   = C_OPB_AWIDTH;
  localparam int unsigned DW   = C_OPB_DWIDTH;
  localparam int unsigned BEW  = C_OPB_DWIDTH / 8;
  localparam int unsigned TO_W = $clog2(C_TIMEOUT_CYCLES + 2);
  localparam int unsigned RT_W = $clog2(C_MAX_RETRY + 2);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_XFER    = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BEW-1:0]    be_q, be_d;
  logic              rnw_q, rnw_d;
  logic [TO_W-1:0]   tout_q, tout_d, tout_inc;
  logic [RT_W-1:0]   retry_q, retry_d, retry_inc;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              m_request_q, m_request_d;
  logic              m_select_q, m_select_d;
  logic              m_rnw_q, m_rnw_d;
  logic [AW-1:0]     m_abus_q, m_abus_d;
  logic [BEW-1:0]    m_be_q, m_be_d;
  logic [DW-1:0]     m_dbus_q, m_dbus_d;
  logic              xfer_next;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rnw_q        <= 1'b0;
      tout_q       <= '0;
      retry_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      m_request_q  <= 1'b0;
      m_select_q   <= 1'b0;
      m_rnw_q      <= 1'b0;
      m_abus_q     <= '0;
      m_be_q       <= '0;
      m_dbus_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rnw_q        <= rnw_d;
      tout_q       <= tout_d;
      retry_q      <= retry_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      m_request_q  <= m_request_d;
      m_select_q   <= m_select_d;
      m_rnw_q      <= m_rnw_d;
      m_abus_q     <= m_abus_d;
      m_be_q       <= m_be_d;
      m_dbus_q     <= m_dbus_d;
    end
  end

  // Next state plus registered outputs decoded from the next state, so every
  // M_* strobe lines up exactly with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rnw_d        = rnw_q;
    tout_d       = tout_q;
    retry_d      = retry_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    tout_inc     = tout_q + TO_W'(!Sl_toutSup);
    retry_inc    = retry_q + RT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          be_d    = cmd_be;
          rnw_d   = cmd_rnw;
          retry_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (OPB_MGrant) begin
          tout_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // Priority: xferAck > errAck > retry > timeout; every failure zeroes rdata.
        if (Sl_xferAck) begin
          if (rnw_q) rsp_rdata_d = OPB_DBus;
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (Sl_errAck) begin
          rsp_rdata_d  = '0;
          rsp_status_d = ST_ERR;
          state_d      = S_RESP;
        end else if (Sl_retry) begin
          retry_d = retry_inc;
          if (retry_inc <= RT_W'(C_MAX_RETRY)) begin
            state_d = S_BACKOFF;
          end else begin
            rsp_rdata_d  = '0;
            rsp_status_d = ST_RETRY;
            state_d      = S_RESP;
          end
        end else begin
          tout_d = tout_inc;
          if (tout_inc == TO_W'(C_TIMEOUT_CYCLES)) begin
            rsp_rdata_d  = '0;
            rsp_status_d = ST_TIMEOUT;
            state_d      = S_RESP;
          end
        end
      end
      S_BACKOFF: state_d = S_REQ;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    xfer_next   = (state_d == S_XFER);
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    m_request_d = (state_d == S_REQ);
    m_select_d  = xfer_next;
    m_rnw_d     = xfer_next && rnw_d;
    m_abus_d    = xfer_next ? addr_d : '0;
    m_be_d      = xfer_next ? be_d : '0;
    m_dbus_d    = (xfer_next && !rnw_d) ? wdata_d : '0;
  end

  // User bit 31 lands on OPB bit 0 by plain MSB-to-MSB assignment.
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign M_request  = m_request_q;
  assign M_select   = m_select_q;
  assign M_RNW      = m_rnw_q;
  assign M_seqAddr  = 1'b0;
  assign M_ABus     = m_abus_q;
  assign M_BE       = m_be_q;
  assign M_DBus     = m_dbus_q;

endmodule

// File: tb/tb_opb_simulink_master.sv
// Scoreboard bench for opb_simulink_master: randomized commands and slave
// behaviour, expected responses from a per-command arithmetic model.
module tb_opb_simulink_master;

  localparam int TO = 16;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        cmd_rnw = 1'b0;
  logic        cmd_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        M_request, M_select, M_RNW, M_seqAddr;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        OPB_MGrant = 1'b0;
  logic [0:31] OPB_DBus = '0;
  logic        Sl_xferAck = 1'b0, Sl_errAck = 1'b0, Sl_retry = 1'b0, Sl_toutSup = 1'b0;

  always #5 clk = ~clk;

  opb_simulink_master dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_be(cmd_be), .cmd_rnw(cmd_rnw), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW),
    .M_seqAddr(M_seqAddr), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .OPB_MGrant(OPB_MGrant), .OPB_DBus(OPB_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup)
  );

  // Slave behaviour for one command: kind 0 xferAck, 1 errAck, 2 never acks.
  typedef struct {
    int gd; int nretry; int retry_at; int kind; int ack_at; int tsup;
    bit also_retry; logic [31:0] dval;
  } scen_t;

  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; bit rnw;
    int status; logic [31:0] rdata; int attempts; int sel; int gaps; int lat; int acc;
  } exp_t;

  exp_t        q[$];
  scen_t       cur;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic scen_t mk(int gd, int nretry, int retry_at, int kind, int ack_at,
                               int tsup, bit also, logic [31:0] dval);
    scen_t s;
    s.gd = gd; s.nretry = nretry; s.retry_at = retry_at; s.kind = kind;
    s.ack_at = ack_at; s.tsup = tsup; s.also_retry = also; s.dval = dval;
    return s;
  endfunction

  // Outcome of a whole command from the slave scenario, by counting attempts and cycles.
  function automatic exp_t model(scen_t s, logic [31:0] addr, logic [31:0] wdata,
                                 logic [3:0] be, bit rnw, logic [31:0] prev, int acc);
    exp_t e;
    int fin;
    e.addr = addr; e.wdata = wdata; e.be = be; e.rnw = rnw; e.acc = acc;
    if (s.nretry > MR) begin
      e.attempts = MR + 1;
      e.sel      = e.attempts * s.retry_at;
      e.status   = 3;
      e.rdata    = 32'h0;
    end else begin
      e.attempts = s.nretry + 1;
      fin        = (s.kind == 2) ? TO + s.tsup : s.ack_at;
      e.sel      = s.nretry * s.retry_at + fin;
      e.status   = s.kind;
      e.rdata    = (s.kind == 0) ? (rnw ? s.dval : prev) : 32'h0;
    end
    e.gaps = e.attempts - 1;
    e.lat  = e.attempts * (s.gd + 1) + e.sel + e.gaps + 1;
    return e;
  endfunction

  task automatic issue(input scen_t s, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit rnw, input bit track);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 400) begin @(negedge clk); w++; end
    if (!cmd_ready) begin check("cmd_ready_wait", 32'(cmd_ready), 32'd1); return; end
    if (track) begin
      e = model(s, addr, wdata, be, rnw, last_rdata, cyc);
      last_rdata = e.rdata;
      q.push_back(e);
    end
    cur = s;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be; cmd_rnw = rnw;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_be = 4'($urandom);
    cmd_rnw = 1'($urandom);
  endtask

  // Slave / arbiter driver, updated on the falling edge.
  initial begin
    int xcnt = 0, rcnt = 0, att = 0;
    cur = mk(0, 0, 1, 0, 1, 0, 1'b0, 32'h0);
    forever begin
      @(negedge clk);
      Sl_xferAck = 1'b0; Sl_errAck = 1'b0; Sl_retry = 1'b0; Sl_toutSup = 1'b0;
      OPB_MGrant = 1'b0; OPB_DBus = $urandom;
      if (!rst_n) begin xcnt = 0; rcnt = 0; att = 0; continue; end
      if (M_request) begin
        OPB_MGrant = (rcnt == cur.gd);
        rcnt++;
      end else begin
        rcnt = 0;
        OPB_MGrant = ($urandom_range(3) == 0);
      end
      if (M_select) begin
        if (xcnt == 0) att++;
        xcnt++;
        if (att <= cur.nretry) begin
          Sl_retry = (xcnt == cur.retry_at);
        end else if (cur.kind == 0) begin
          Sl_xferAck = (xcnt == cur.ack_at);
          Sl_retry   = cur.also_retry && (xcnt == cur.ack_at);
          if (xcnt == cur.ack_at) OPB_DBus = cur.dval;
        end else if (cur.kind == 1) begin
          Sl_errAck = (xcnt == cur.ack_at);
          Sl_retry  = cur.also_retry && (xcnt == cur.ack_at);
        end else begin
          Sl_toutSup = (xcnt <= cur.tsup);
        end
      end else begin
        xcnt = 0;
        Sl_xferAck = ($urandom_range(3) == 0);
        Sl_errAck  = ($urandom_range(3) == 0);
        Sl_retry   = ($urandom_range(3) == 0);
        Sl_toutSup = ($urandom_range(1) == 0);
      end
      if (cmd_ready) att = 0;
    end
  end

  // Monitor: tracks the bus for the command at the head of the queue and
  // compares everything when rsp_valid appears.
  initial begin
    int sel = 0, att = 0, gaps = 0;
    bit prev_sel = 1'b0, bus_bad = 1'b0, exp_rdy = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); sel = 0; att = 0; gaps = 0; prev_sel = 1'b0; exp_rdy = 1'b0;
        continue;
      end
      if (exp_rdy) begin
        check("ready_after_rsp", 32'(cmd_ready), 32'd1);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        exp_rdy = 1'b0;
      end
      if (M_seqAddr || (M_request && M_select)) bus_bad = 1'b1;
      if (!M_select && (M_RNW || M_ABus != 0 || M_BE != 0 || M_DBus != 0)) bus_bad = 1'b1;
      if (q.size() > 0 && cyc > q[0].acc) begin
        e = q[0];
        if (cmd_ready) bus_bad = 1'b1;
        if (M_select) begin
          sel++;
          if (!prev_sel) att++;
          if (M_ABus != e.addr || M_BE != e.be || M_RNW != e.rnw ||
              M_DBus != (e.rnw ? 32'h0 : e.wdata)) bus_bad = 1'b1;
        end else if (!M_request && sel > 0 && !rsp_valid) begin
          gaps++;
        end
        if (rsp_valid) begin
          check("status", 32'(rsp_status), 32'(e.status));
          check("rdata", rsp_rdata, e.rdata);
          check("attempts", 32'(att), 32'(e.attempts));
          check("select_cycles", 32'(sel), 32'(e.sel));
          check("backoff_gaps", 32'(gaps), 32'(e.gaps));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("bus_ok", 32'(bus_bad), 32'd0);
          void'(q.pop_front());
          sel = 0; att = 0; gaps = 0; bus_bad = 1'b0; exp_rdy = 1'b1;
        end
      end else if (rsp_valid) begin
        check("spurious_rsp", 32'(rsp_valid), 32'd0);
      end
      prev_sel = M_select;
    end
  end

  initial begin
    scen_t s;
    int w;
    int r;
    // reset state
    #23;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_m_select", 32'(M_select), 32'd0);
    check("rst_m_request", 32'(M_request), 32'd0);
    check("rst_m_abus", M_ABus, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 32'(cmd_ready), 32'd1);

    // directed cases
    issue(mk(0, 0, 1, 0, 1, 0, 1'b0, 32'h0), 32'h0100E000, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b1);
    issue(mk(0, 0, 1, 0, 3, 0, 1'b0, 32'h12345678), 32'h00002000, 32'h0, 4'hF, 1'b1, 1'b1);
    issue(mk(0, 0, 1, 2, 1, 0, 1'b0, 32'h0), 32'h00003000, 32'h0, 4'h3, 1'b1, 1'b1);
    issue(mk(1, 0, 1, 2, 1, 20, 1'b0, 32'h0), 32'h00004000, 32'h11, 4'hC, 1'b0, 1'b1);
    issue(mk(0, 4, 1, 0, 1, 0, 1'b0, 32'h0), 32'h00005000, 32'h22, 4'h1, 1'b0, 1'b1);
    issue(mk(0, 0, 1, 1, 2, 0, 1'b1, 32'h0), 32'h00006000, 32'h33, 4'h8, 1'b1, 1'b1);
    issue(mk(2, 0, 1, 0, 2, 0, 1'b1, 32'hCAFEF00D), 32'h00007000, 32'h0, 4'hF, 1'b1, 1'b1);
    issue(mk(0, 3, 2, 0, 1, 0, 1'b0, 32'h0), 32'h00008000, 32'h44, 4'hF, 1'b0, 1'b1);

    // reset in the middle of a transfer
    issue(mk(0, 0, 1, 2, 1, 0, 1'b0, 32'h0), 32'hDEAD0000, 32'h55, 4'hF, 1'b0, 1'b0);
    w = 0;
    while (!M_select && w < 50) begin @(negedge clk); w++; end
    check("select_before_reset", 32'(M_select), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_select_drop", 32'(M_select), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 32'h0;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 32'(cmd_ready), 32'd1);
    repeat (5) @(negedge clk);

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(9);
      s = mk($urandom_range(3), ($urandom_range(3) == 0) ? $urandom_range(1, 5) : 0,
             $urandom_range(1, 4), (r < 6) ? 0 : (r < 8) ? 1 : 2, $urandom_range(1, 6),
             $urandom_range(5), ($urandom_range(3) == 0), $urandom);
      issue(s, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'b1);
    end

    w = 0;
    while (q.size() > 0 && w < 2000) begin @(negedge clk); w++; end
    check("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
